// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared opcode, step-count and state definitions for the
//               FPU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [5:0] LAST_CNT_ADD = 6'd20;
    localparam logic [5:0] LAST_CNT_MUL = 6'd55;
    localparam logic [5:0] LAST_CNT_DIV = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    function automatic logic [5:0] last_cnt(input logic [1:0] op);
        case (op)
            OP_MUL:  last_cnt = LAST_CNT_MUL;
            OP_DIV:  last_cnt = LAST_CNT_DIV;
            default: last_cnt = LAST_CNT_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin selector; ties go to the side not served
//               last, a lone request wins outright.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        gnt   = (req0 & req1) ? ~last : req1;
    end

endmodule
`default_nettype wire

// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sequencer
// Description : Arbitrates two requesters, drives operands and a step counter
//               to the arithmetic units and captures the selected result.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_sequencer
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic [5:0]  cnt,
    input  logic [31:0] add_result,
    input  logic        add_ovf,
    input  logic [31:0] mul_result,
    input  logic        mul_ovf,
    input  logic [31:0] div_result,
    input  logic        div_ovf,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [31:0] result,
    output logic        overflow
);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [1:0]  op_q, op_d;
    logic        id_q, id_d, last_q, last_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        done_q, done_d, done_id_q, done_id_d, ovf_q, ovf_d;
    logic        w_arb_gnt, w_arb_valid;

    rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .gnt   (w_arb_gnt),
        .valid (w_arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            op_q      <= OP_ADD;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= 32'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            id_q      <= id_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 6'd0;
                if (w_arb_valid) begin
                    a_d     = w_arb_gnt ? a1  : a0;
                    b_d     = w_arb_gnt ? b1  : b0;
                    op_d    = w_arb_gnt ? op1 : op0;
                    id_d    = w_arb_gnt;
                    last_d  = w_arb_gnt;
                    gnt0_d  = ~w_arb_gnt;
                    gnt1_d  = w_arb_gnt;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Saturating compare keeps the 63-step divide from wrapping.
                if (cnt_q == last_cnt(op_q)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_CAPTURE: begin
                case (op_q)
                    OP_MUL: begin
                        result_d = mul_result;
                        ovf_d    = mul_ovf;
                    end
                    OP_DIV: begin
                        result_d = div_result;
                        ovf_d    = div_ovf;
                    end
                    default: begin
                        result_d = add_result;
                        ovf_d    = add_ovf;
                    end
                endcase
                done_d    = 1'b1;
                done_id_d = id_q;
                cnt_d     = 6'd0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        unit_a   = a_q;
        unit_b   = (op_q == OP_SUB) ? {~b_q[31], b_q[30:0]} : b_q;
        cnt      = cnt_q;
        gnt0     = gnt0_q;
        gnt1     = gnt1_q;
        busy     = (state_q != ST_IDLE);
        done     = done_q;
        done_id  = done_id_q;
        result   = result_q;
        overflow = ovf_q;
    end

endmodule
`default_nettype wire
